reg_file: RTL and testbench

- 32 x 32-bit RISC-V integer register file, sitting directly upstream of the ALU.
- Two combinational read ports drive the ALU operands (in_a, in_b).
- One synchronous write port is fed by the writeback path.
- x0 is hardwired to zero.

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_if.sv | 26 ++
 rtl/reg_file.sv | 43 ++++
 tb/tb_reg_file.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the integer register file.
package reg_file_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/reg_file_if.sv
// Write-port and read-port bundle of the register file, with driver, DUT and monitor views.
interface reg_file_if;
  import reg_file_pkg::*;

  logic      wr_en;
  reg_addr_t wr_reg;
  word_t     wr_data;
  reg_addr_t rd_reg_1;
  reg_addr_t rd_reg_2;
  word_t     rd_data_1;
  word_t     rd_data_2;

  modport master (
    output wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    input  rd_data_1, rd_data_2
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    output rd_data_1, rd_data_2
  );

  modport monitor (
    input wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2, rd_data_1, rd_data_2
  );
endinterface

// File: rtl/reg_file.sv
// 32 x XLEN RISC-V integer register file: two combinational reads, one synchronous write, x0 tied to zero.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file #(
  parameter int unsigned XLEN     = reg_file_pkg::XLEN,
  parameter int unsigned NUM_REGS = reg_file_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_ok;

  assign wr_ok = bus.wr_en && (bus.wr_reg != ADDR_W'(0));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.wr_reg] = bus.wr_data;
  end

  // Reset wins over a simultaneous write, so the pending write is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    bus.rd_data_1 = (bus.rd_reg_1 == ADDR_W'(0)) ? '0 : regs_q[bus.rd_reg_1];
    bus.rd_data_2 = (bus.rd_reg_2 == ADDR_W'(0)) ? '0 : regs_q[bus.rd_reg_2];
`ifdef RF_BYPASS_EN
    // wr_ok already excludes x0, so forwarding can never break the zero rule.
    if (!rst && wr_ok && (bus.rd_reg_1 == bus.wr_reg)) bus.rd_data_1 = bus.wr_data;
    if (!rst && wr_ok && (bus.rd_reg_2 == bus.wr_reg)) bus.rd_data_2 = bus.wr_data;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboarded bench for reg_file; expectations follow RF_BYPASS_EN when it is defined.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk;
  logic rst;
  reg_file_if bus ();

  reg_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(REG_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  word_t       model [NUM_REGS];
  word_t       exp_q [$];
  bit          wr_cov  [NUM_REGS];
  bit          rd_cov  [NUM_REGS];
  int unsigned same_hits = 0;

  function automatic word_t exp_rd(reg_addr_t a);
    if (a == ZERO_REG) return '0;
`ifdef RF_BYPASS_EN
    if (!rst && bus.wr_en && bus.wr_reg != ZERO_REG && bus.wr_reg == a) return bus.wr_data;
`endif
    return model[a];
  endfunction

  // Reference-model update for the edge that is about to happen.
  function automatic void model_edge();
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (bus.wr_en && bus.wr_reg != ZERO_REG) begin
      model[bus.wr_reg] = bus.wr_data;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(input reg_addr_t a, input word_t d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_reg = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    word_t g1, g2, e1, e2;
    @(negedge clk);
    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      @(negedge clk);
      bus.rd_reg_1 = reg_addr_t'(i);
      bus.rd_reg_2 = reg_addr_t'(NUM_REGS - 1 - i);
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      g1 = bus.rd_data_1; g2 = bus.rd_data_2;
      e1 = exp_q.pop_front(); e2 = exp_q.pop_front();
      checks++;
      if (g1 !== e1) begin errors++; $display("FAIL reset_rd1 idx=%0d got=%h exp=%h", i, g1, e1); end
      checks++;
      if (g2 !== e2) begin errors++; $display("FAIL reset_rd2 idx=%0d got=%h exp=%h", NUM_REGS - 1 - i, g2, e2); end
    end
  endtask

  task automatic test_basic();
    word_t g, e;
    do_write(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    bus.rd_reg_1 = 5'd5; bus.rd_reg_2 = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL basic_rd1 got=%h exp=%h", g, e); end
    g = bus.rd_data_2; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL basic_rd2 got=%h exp=%h", g, e); end
    bus.rd_reg_1 = 5'd4; bus.rd_reg_2 = 5'd6;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL basic_neighbour_x4 got=%h exp=%h", g, e); end
    g = bus.rd_data_2; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL basic_neighbour_x6 got=%h exp=%h", g, e); end
  endtask

  task automatic test_x0();
    word_t g, e;
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_reg = 5'd0; bus.wr_data = 32'hFFFFFFFF;
    bus.rd_reg_1 = 5'd0; bus.rd_reg_2 = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    g = bus.rd_data_2; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL x0_same_cycle got=%h exp=%h", g, e); end
    tick();
    bus.wr_en = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL x0_after_write got=%h exp=%h", g, e); end
  endtask

  task automatic test_wr_disable();
    word_t g, e;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.wr_reg = 5'd7; bus.wr_data = 32'h12345678;
    bus.rd_reg_1 = 5'd7;
    tick();
    exp_q.push_back(32'h0);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL wr_disabled_x7 got=%h exp=%h", g, e); end
  endtask

  task automatic test_raw();
    word_t g, e;
    do_write(5'd9, 32'h1);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_reg = 5'd9; bus.wr_data = 32'hA5A5A5A5;
    bus.rd_reg_1 = 5'd9; bus.rd_reg_2 = 5'd9;
`ifdef RF_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(32'h1);
`endif
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL raw_before_edge got=%h exp=%h", g, e); end
    tick();
    bus.wr_en = 1'b0;
    exp_q.push_back(32'hA5A5A5A5);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL raw_after_edge got=%h exp=%h", g, e); end
  endtask

  task automatic test_reset_priority();
    word_t g, e;
    do_write(5'd31, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_reg = 5'd3; bus.wr_data = 32'h55;
    bus.rd_reg_1 = 5'd3; bus.rd_reg_2 = 5'd31;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFEF00D);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL no_forward_in_reset got=%h exp=%h", g, e); end
    g = bus.rd_data_2; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL x31_before_reset got=%h exp=%h", g, e); end
    tick();
    rst = 1'b0; bus.wr_en = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_drops_write_x3 got=%h exp=%h", g, e); end
    g = bus.rd_data_2; e = exp_q.pop_front(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_clears_x31 got=%h exp=%h", g, e); end
  endtask

  task automatic test_random();
    word_t g, e;
    int unsigned wr_seen, rd_seen;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 99) == 0);
      bus.wr_en    = ($urandom_range(0, 3) != 0);
      bus.wr_reg   = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.wr_data  = word_t'($urandom);
      bus.rd_reg_1 = ($urandom_range(0, 3) == 0) ? bus.wr_reg
                                                 : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.rd_reg_2 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      wr_cov[bus.wr_reg] = 1'b1;
      rd_cov[bus.rd_reg_1] = 1'b1;
      rd_cov[bus.rd_reg_2] = 1'b1;
      if (bus.wr_en && (bus.rd_reg_1 == bus.wr_reg || bus.rd_reg_2 == bus.wr_reg)) same_hits++;
      exp_q.push_back(exp_rd(bus.rd_reg_1));
      exp_q.push_back(exp_rd(bus.rd_reg_2));
      #1;
      g = bus.rd_data_1; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rand_rd1 n=%0d idx=%0d got=%h exp=%h", n, bus.rd_reg_1, g, e); end
      g = bus.rd_data_2; e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rand_rd2 n=%0d idx=%0d got=%h exp=%h", n, bus.rd_reg_2, g, e); end
      tick();
    end
    rst = 1'b0; bus.wr_en = 1'b0;
    wr_seen = 0; rd_seen = 0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_cov[i]) wr_seen++;
      if (rd_cov[i]) rd_seen++;
    end
    $display("coverage: wr_reg %0d/%0d, rd_reg %0d/%0d, same-index hits %0d",
             wr_seen, NUM_REGS, rd_seen, NUM_REGS, same_hits);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
    bus.rd_reg_1 = '0; bus.rd_reg_2 = '0;
    test_reset();
    test_basic();
    test_x0();
    test_wr_disable();
    test_raw();
    test_reset_priority();
    test_random();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
